// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared types and default sizes for the mpmc11 read-strip path.
//   mpmc11_state_t      : encoding of the mpmc11 controller state machine
//   DEF_STRIP_W         : default width of one memory strip (bits)
//   DEF_MAX_STRIPS      : default number of strips held in the response buffer
//   DEF_TO_LIMIT        : default cycles in one non-IDLE state before time-out
package mpmc11_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESET1     = 3'd1,
    READ_DATA0  = 3'd2,
    READ_DATA1  = 3'd3,
    READ_DATA2  = 3'd4,
    WRITE_DATA0 = 3'd5,
    WRITE_DATA1 = 3'd6,
    DONE        = 3'd7
  } mpmc11_state_t;

  localparam int DEF_STRIP_W    = 128;
  localparam int DEF_MAX_STRIPS = 4;
  localparam int DEF_TO_LIMIT   = 2000;

endpackage

// File: rtl/mpmc11_state_timeout.sv
// mpmc11_state_timeout: flags a state machine that has sat in one non-IDLE
// state for TO_LIMIT cycles.
//   clk, rst : clock, synchronous active-high reset
//   state    : current mpmc11 state
//   to       : registered time-out, high while the dwell count is at TO_LIMIT
module mpmc11_state_timeout
  import mpmc11_pkg::*;
#(
  parameter int TO_LIMIT = DEF_TO_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  input  mpmc11_state_t state,
  output logic          to
);

  localparam int                CNT_W = $clog2(TO_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TO_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  mpmc11_state_t    prev_state;

  // A state change restarts the dwell count; clear wins over increment.
  always_comb begin
    cnt_next = cnt;
    if (state == IDLE || state != prev_state) begin
      cnt_next = '0;
    end else if (cnt != LIMIT) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      prev_state <= IDLE;
      to         <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      prev_state <= state;
      to         <= (cnt_next == LIMIT);
    end
  end

endmodule

// File: rtl/mpmc11_strip_collector.sv
// mpmc11_strip_collector: counts strips issued to and returned from memory,
// generates the per-strip app address and assembles read beats into one
// wide response word.
//   clk, rst        : clock, synchronous active-high reset
//   state           : current mpmc11 state
//   rdy             : memory app_rdy
//   rd_data_valid   : read beat valid
//   rd_data         : read beat data (one strip)
//   num_strips      : strips in the current request (1..63)
//   base_adr        : byte address of the first strip
//   req_strip_cnt   : strips issued so far (registered)
//   resp_strip_cnt  : strips received including this cycle's beat
//   app_adr         : address of the next strip to issue
//   resp_data       : assembled response, strip 0 in the LSBs
//   resp_v          : one-cycle pulse when the response is complete
//   to              : state time-out
//   err_ovf         : sticky, more than MAX_STRIPS beats received
//   err_stray       : sticky, beat received in IDLE
module mpmc11_strip_collector
  import mpmc11_pkg::*;
#(
  parameter int STRIP_W    = DEF_STRIP_W,
  parameter int MAX_STRIPS = DEF_MAX_STRIPS,
  parameter int TO_LIMIT   = DEF_TO_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  mpmc11_state_t                 state,
  input  logic                          rdy,
  input  logic                          rd_data_valid,
  input  logic [STRIP_W-1:0]            rd_data,
  input  logic [5:0]                    num_strips,
  input  logic [31:0]                   base_adr,
  output logic [5:0]                    req_strip_cnt,
  output logic [5:0]                    resp_strip_cnt,
  output logic [31:0]                   app_adr,
  output logic [STRIP_W*MAX_STRIPS-1:0] resp_data,
  output logic                          resp_v,
  output logic                          to,
  output logic                          err_ovf,
  output logic                          err_stray
);

  localparam logic [31:0] STRIP_BYTES = 32'(STRIP_W / 8);

  logic [5:0] req_cnt;
  logic [5:0] resp_cnt;
  logic       done;
  logic       clr_req;
  logic       in_read;
  logic       beat;
  logic       fire;

  assign clr_req = (state == IDLE) || (state == PRESET1);
  assign in_read = (state == READ_DATA0) || (state == READ_DATA1) ||
                   (state == READ_DATA2);
  assign beat    = rd_data_valid && in_read;

  assign req_strip_cnt = req_cnt;
  assign app_adr       = base_adr + ({26'd0, req_cnt} * STRIP_BYTES);

  // Lookahead so the controller leaves READ_DATA2 on the last beat itself.
  assign resp_strip_cnt = (resp_cnt == 6'd63) ? 6'd63 : resp_cnt + {5'd0, beat};

  // done blocks a second pulse if further beats keep matching num_strips.
  assign fire = beat && (resp_strip_cnt == num_strips) && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt   <= '0;
      resp_cnt  <= '0;
      done      <= 1'b0;
      resp_v    <= 1'b0;
      err_ovf   <= 1'b0;
      err_stray <= 1'b0;
    end else begin
      if (clr_req) begin
        req_cnt <= '0;
      end else if (state == READ_DATA0 && rdy && req_cnt != 6'd63) begin
        req_cnt <= req_cnt + 6'd1;
      end

      if (clr_req) begin
        resp_cnt <= '0;
        done     <= 1'b0;
      end else begin
        if (beat && resp_cnt != 6'd63) resp_cnt <= resp_cnt + 6'd1;
        if (fire) done <= 1'b1;
      end

      resp_v <= fire;
      if (beat && int'(resp_cnt) >= MAX_STRIPS) err_ovf <= 1'b1;
      if (rd_data_valid && state == IDLE) err_stray <= 1'b1;
    end
  end

  // Beats beyond the buffer are dropped; stored strips persist across IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data <= '0;
    end else begin
      for (int i = 0; i < MAX_STRIPS; i++) begin
        if (beat && int'(resp_cnt) == i) resp_data[i*STRIP_W +: STRIP_W] <= rd_data;
      end
    end
  end

  mpmc11_state_timeout #(
    .TO_LIMIT (TO_LIMIT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .to    (to)
  );

endmodule

// File: tb/tb_mpmc11_strip_collector.sv
// Directed bench for mpmc11_strip_collector: address generation, response
// assembly, overflow, stray beats, time-out and mid-request reset.
module tb_mpmc11_strip_collector;
  import mpmc11_pkg::*;

  localparam int SW  = 128;
  localparam int MS  = 4;
  localparam int TOL = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  mpmc11_state_t        state;
  logic                 rdy;
  logic                 rd_data_valid;
  logic [SW-1:0]        rd_data;
  logic [5:0]           num_strips;
  logic [31:0]          base_adr;
  logic [5:0]           req_strip_cnt;
  logic [5:0]           resp_strip_cnt;
  logic [31:0]          app_adr;
  logic [SW*MS-1:0]     resp_data;
  logic                 resp_v;
  logic                 to;
  logic                 err_ovf;
  logic                 err_stray;

  int errors = 0;
  int checks = 0;

  logic [SW-1:0]    dat_a;
  logic [SW-1:0]    dat_b;
  logic [SW*MS-1:0] exp_b;
  logic [31:0]      w;

  always #5 clk = ~clk;

  mpmc11_strip_collector #(
    .STRIP_W    (SW),
    .MAX_STRIPS (MS),
    .TO_LIMIT   (TOL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .state          (state),
    .rdy            (rdy),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .num_strips     (num_strips),
    .base_adr       (base_adr),
    .req_strip_cnt  (req_strip_cnt),
    .resp_strip_cnt (resp_strip_cnt),
    .app_adr        (app_adr),
    .resp_data      (resp_data),
    .resp_v         (resp_v),
    .to             (to),
    .err_ovf        (err_ovf),
    .err_stray      (err_stray)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SW*MS-1:0] obs,
                     input logic [SW*MS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    dat_a = {4{32'hAAAA_AAAA}};
    dat_b = {4{32'hBBBB_BBBB}};
    rst = 1'b1; state = IDLE; rdy = 1'b0; rd_data_valid = 1'b0;
    rd_data = '0; num_strips = 6'd0; base_adr = 32'd0;
    step(); step();
    chk("rst_req", req_strip_cnt, 0);
    chk("rst_resp", resp_strip_cnt, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_to", to, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_stray", err_stray, 0);
    chk("rst_data", resp_data, 0);
    rst = 1'b0;

    // Two-strip request: issue addresses, then two beats.
    num_strips = 6'd2; base_adr = 32'h1000; state = PRESET1;
    step();
    state = READ_DATA0; rdy = 1'b1;
    #1;
    chk("adr0", app_adr, 32'h1000);
    chk("req0", req_strip_cnt, 0);
    step();
    chk("req1", req_strip_cnt, 1);
    chk("adr1", app_adr, 32'h1010);
    step();
    chk("req2", req_strip_cnt, 2);
    rdy = 1'b0; state = READ_DATA1;
    step();
    chk("req2_hold", req_strip_cnt, 2);
    state = READ_DATA2; rd_data_valid = 1'b1; rd_data = dat_a;
    #1;
    chk("resp_cnt1", resp_strip_cnt, 1);
    step();
    rd_data = dat_b;
    #1;
    chk("resp_cnt2", resp_strip_cnt, 2);
    chk("resp_v_early", resp_v, 0);
    step();
    rd_data_valid = 1'b0;
    #1;
    chk("resp_v_pulse", resp_v, 1);
    chk("resp_data_ab", resp_data[255:0], {dat_b, dat_a});
    chk("resp_cnt_hold", resp_strip_cnt, 2);
    step();
    chk("resp_v_once", resp_v, 0);
    state = IDLE;
    step();
    chk("idle_req", req_strip_cnt, 0);
    chk("idle_resp", resp_strip_cnt, 0);
    chk("idle_data_held", resp_data[255:0], {dat_b, dat_a});

    // Five beats into a four-strip buffer.
    num_strips = 6'd5; state = PRESET1;
    step();
    state = READ_DATA2;
    exp_b = '0;
    for (int i = 0; i < 5; i++) begin
      w = 32'(i + 1);
      rd_data = {w, w, w, w};
      rd_data_valid = 1'b1;
      if (i < MS) exp_b[i*SW +: SW] = {w, w, w, w};
      step();
      if (i == 3) begin
        chk("ovf_before", err_ovf, 0);
        chk("resp_v_before5", resp_v, 0);
      end
    end
    rd_data_valid = 1'b0;
    #1;
    chk("ovf_set", err_ovf, 1);
    chk("resp_v5", resp_v, 1);
    chk("resp_data5", resp_data, exp_b);
    step();
    chk("resp_v5_once", resp_v, 0);
    rd_data_valid = 1'b1; rd_data = '1;
    step();
    rd_data_valid = 1'b0;
    #1;
    chk("resp_v_extra", resp_v, 0);
    chk("data_extra_drop", resp_data, exp_b);
    state = IDLE;
    step();
    chk("ovf_sticky", err_ovf, 1);

    // Stray beat in IDLE.
    rd_data_valid = 1'b1; rd_data = '1;
    step();
    rd_data_valid = 1'b0;
    #1;
    chk("stray_set", err_stray, 1);
    chk("stray_resp", resp_strip_cnt, 0);
    chk("stray_req", req_strip_cnt, 0);
    chk("stray_data", resp_data, exp_b);

    // Beat in a write state is ignored.
    state = WRITE_DATA0; rd_data_valid = 1'b1;
    step();
    rd_data_valid = 1'b0;
    #1;
    chk("wr_resp", resp_strip_cnt, 0);
    chk("wr_data", resp_data, exp_b);

    // Time-out while dwelling in READ_DATA2.
    state = READ_DATA2;
    for (int i = 0; i < TOL - 2; i++) step();
    chk("to_low", to, 0);
    for (int i = 0; i < 4; i++) step();
    chk("to_high", to, 1);
    state = IDLE;
    step();
    chk("to_clear", to, 0);

    // Reset clears sticky flags, then abandons a request mid-way.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovf_rst", err_ovf, 0);
    chk("stray_rst", err_stray, 0);
    num_strips = 6'd2; state = PRESET1;
    step();
    state = READ_DATA2; rd_data_valid = 1'b1; rd_data = dat_a;
    step();
    rd_data_valid = 1'b0; rst = 1'b1;
    step();
    chk("mid_rst_resp", resp_strip_cnt, 0);
    chk("mid_rst_req", req_strip_cnt, 0);
    chk("mid_rst_v", resp_v, 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_to", to, 0);
    rst = 1'b0; state = IDLE;
    step();
    rd_data_valid = 1'b1; rd_data = dat_b;
    step();
    rd_data_valid = 1'b0;
    #1;
    chk("post_stray", err_stray, 1);
    chk("post_ovf", err_ovf, 0);
    chk("post_v", resp_v, 0);
    chk("post_data", resp_data, 0);
    chk("post_resp", resp_strip_cnt, 0);
    step();
    chk("post_v2", resp_v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpmc11_strip_collector.md
MPMC11_STRIP_COLLECTOR -- requirements
Module: mpmc11_strip_collector

Interface
REQ-001 Parameter STRIP_W, default 128: width of one memory strip (app data beat) in bits.
REQ-002 Parameter MAX_STRIPS, default 4: number of strips held in the response buffer.
REQ-003 Parameter TO_LIMIT, default 2000: cycles in one non-IDLE state before time-out.
REQ-004 clk  in  1: system clock; all state changes on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 state  in  mpmc11_state_t: current state of the mpmc11 state machine.
REQ-007 rdy  in  1: memory controller app_rdy.
REQ-008 rd_data_valid  in  1: memory read beat valid.
REQ-009 rd_data  in  STRIP_W: memory read beat data.
REQ-010 num_strips  in  6: number of strips in the current request, 1..63.
REQ-011 base_adr  in  32: byte address of the first strip.
REQ-012 req_strip_cnt  out  6: strips issued to memory for the current request.
REQ-013 resp_strip_cnt  out  6: strips received, including the current-cycle beat.
REQ-014 app_adr  out  32: address of the next strip to issue.
REQ-015 resp_data  out  STRIP_W*MAX_STRIPS: assembled read response, strip 0 in the LSBs.
REQ-016 resp_v  out  1: one-cycle pulse when the response is complete.
REQ-017 to  out  1: state-machine time-out.
REQ-018 err_ovf  out  1: sticky flag, set when more than MAX_STRIPS beats are received.
REQ-019 err_stray  out  1: sticky flag, set when a beat arrives in IDLE.

Function
REQ-020 The internal request counter SHALL clear to 0 on any cycle with state==IDLE or PRESET1.
REQ-021 The internal request counter SHALL increment by 1 on each cycle with state==READ_DATA0 and rdy==1.
REQ-022 The internal request counter SHALL saturate at 63.
REQ-023 req_strip_cnt SHALL be the registered request count; the READ_DATA1 comparison therefore sees the updated value one cycle after issue.
REQ-024 app_adr SHALL be combinational: base_adr + req_strip_cnt*(STRIP_W/8), modulo 2^32.
REQ-025 The internal response count SHALL clear in IDLE or PRESET1 and SHALL increment on each rd_data_valid in READ_DATA0, READ_DATA1 or READ_DATA2.
REQ-026 resp_strip_cnt SHALL equal the registered response count plus rd_data_valid (combinational lookahead), so that the READ_DATA2 exit coincides with the last beat.
REQ-027 A beat with registered response count k < MAX_STRIPS SHALL be written into slice k of resp_data.
REQ-028 A beat with k >= MAX_STRIPS SHALL be discarded and SHALL set err_ovf.
REQ-029 resp_data SHALL hold its value until the next accepted beat; it is not cleared on IDLE.
REQ-030 resp_v SHALL pulse high for exactly one cycle, the cycle after the beat that makes resp_strip_cnt equal num_strips.
REQ-031 resp_v SHALL NOT fire again for the same request.
REQ-032 rd_data_valid in IDLE SHALL set err_stray and SHALL leave the counters and resp_data unchanged.
REQ-033 rd_data_valid in any other non-read state SHALL be ignored without setting a flag.
REQ-034 The time-out counter SHALL clear when state==IDLE or when state differs from its value in the previous cycle.
REQ-035 Otherwise the time-out counter SHALL increment, saturating at TO_LIMIT.
REQ-036 to SHALL be registered, high when the time-out count equals TO_LIMIT, and low the cycle after state returns to IDLE.
REQ-037 Simultaneous increment and clear on either counter: the clear SHALL win.

Reset
REQ-038 While rst is high, all counters, resp_v, to, err_ovf and err_stray SHALL be 0 on the next edge.
REQ-039 While rst is high, resp_data SHALL be 0.
REQ-040 Reset mid-request SHALL abandon the request; no resp_v SHALL follow for it.
REQ-041 The sticky flags SHALL clear only on rst.

Structure
REQ-042 mpmc11_state_t, STRIP_W, MAX_STRIPS and TO_LIMIT defaults SHALL reside in mpmc11_pkg.
REQ-043 The time-out counter SHALL be a sub-module named mpmc11_state_timeout.
REQ-044 All other logic SHALL be flat in mpmc11_strip_collector.

Verification
REQ-045 num_strips=2, base_adr=0x1000, rdy=1 in READ_DATA0 -> app_adr 0x1000 then 0x1010; req_strip_cnt 1 then 2.
REQ-046 Two beats 0xA.., 0xB.. in READ_DATA2 -> resp_strip_cnt 1 then 2; resp_v one cycle after beat 2; resp_data[255:0]={B,A}.
REQ-047 num_strips=5, MAX_STRIPS=4, five beats -> slices 0..3 filled, err_ovf=1, resp_v pulses once.
REQ-048 rd_data_valid in IDLE -> err_stray=1; counters stay 0.
REQ-049 Hold state=READ_DATA2 for TO_LIMIT cycles -> to=1; drive IDLE -> to=0 next cycle.
REQ-050 Assert rst after one of two beats -> all outputs 0; a later beat in IDLE sets only err_stray.
